// File: rtl/lane_serializer_pkg.sv
// Shared definitions for the lane serializer: FSM encoding, default sizes,
// bypass index and the length clamp rule.
package lane_serializer_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   localparam int DEF_ARRAY_SIZE   = 9;
   localparam int DEF_DATA_SIZE    = 16;
   localparam int DEF_DIMDATA_SIZE = 16;
   localparam int BYPASS_INDEX     = DEF_ARRAY_SIZE;

   // A zero or oversized request means "send the whole vector".
   function automatic int effective_len(input int len, input int max_len);
      return ((len == 0) || (len > max_len)) ? max_len : len;
   endfunction

endpackage

// File: rtl/lane_serializer_lane_pick.sv
// Combinational lane extraction: returns lane 'index' of a packed vector,
// or zero for an index outside the vector.
module lane_pick
   import lane_serializer_pkg::*;
#(
   parameter int array_size = DEF_ARRAY_SIZE,
   parameter int data_size  = DEF_DATA_SIZE,
   parameter int index_size = DEF_DIMDATA_SIZE
) (
   input  logic [array_size*data_size-1:0] vec,
   input  logic [index_size-1:0]           index,
   output logic [data_size-1:0]            lane
);

   localparam logic [index_size-1:0] lane_count = index_size'(array_size);

   logic [array_size*data_size-1:0] shifted;

   assign shifted = (index < lane_count) ? (vec >> (data_size * index)) : '0;
   assign lane    = shifted[data_size-1:0];

endmodule

// File: rtl/lane_serializer.sv
// Serializes a captured vector of lanes into single-word beats with a
// valid/ready output handshake, ascending or descending, or one bypass beat.
module lane_serializer
   import lane_serializer_pkg::*;
#(
   parameter int array_size   = DEF_ARRAY_SIZE,
   parameter int data_size    = DEF_DATA_SIZE,
   parameter int dimdata_size = DEF_DIMDATA_SIZE
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [array_size*data_size-1:0] in_vec,
   input  logic [dimdata_size-1:0]        in_len,
   input  logic                           in_rev,
   input  logic                           bypass_en,
   input  logic [data_size-1:0]           bypass_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [data_size-1:0]           out_data,
   output logic [dimdata_size-1:0]        out_index,
   output logic                           out_last
);

   localparam logic [dimdata_size-1:0] len_max = dimdata_size'(array_size);
   localparam logic [dimdata_size-1:0] one     = dimdata_size'(1);

   state_t                          state_reg, state_next;
   logic [array_size*data_size-1:0] vec_reg, vec_next;
   logic [dimdata_size-1:0]         len_reg, len_next;
   logic                            rev_reg, rev_next;
   logic [dimdata_size-1:0]         cnt_reg, cnt_next;
   logic [data_size-1:0]            data_reg, data_next;
   logic [dimdata_size-1:0]         index_reg, index_next;
   logic                            last_reg, last_next;

   logic                            accept;
   logic                            advance;
   logic [dimdata_size-1:0]         eff_len;
   logic [dimdata_size-1:0]         beat_next;
   logic [dimdata_size-1:0]         first_lane;
   logic [dimdata_size-1:0]         next_lane;
   logic [array_size*data_size-1:0] pick_vec;
   logic [dimdata_size-1:0]         pick_idx;
   logic [data_size-1:0]            pick_lane;

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == STREAM);
   assign out_data  = data_reg;
   assign out_index = index_reg;
   assign out_last  = last_reg;

   assign accept     = in_valid && (state_reg == IDLE);
   assign advance    = (state_reg == STREAM) && out_ready && !last_reg;
   assign eff_len    = dimdata_size'(effective_len(int'(in_len), array_size));
   assign beat_next  = cnt_reg + one;
   assign first_lane = in_rev ? (eff_len - one) : '0;
   assign next_lane  = rev_reg ? (len_reg - one - beat_next) : beat_next;

   // The first beat is taken straight from in_vec so it is ready the cycle after acceptance.
   assign pick_vec = accept ? in_vec : vec_reg;
   assign pick_idx = accept ? first_lane : next_lane;

   lane_pick #(
      .array_size (array_size),
      .data_size  (data_size),
      .index_size (dimdata_size)
   ) u_lane_pick (
      .vec   (pick_vec),
      .index (pick_idx),
      .lane  (pick_lane)
   );

   always_comb begin
      state_next = state_reg;
      vec_next   = vec_reg;
      len_next   = len_reg;
      rev_next   = rev_reg;
      cnt_next   = cnt_reg;
      data_next  = data_reg;
      index_next = index_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               state_next = STREAM;
               vec_next   = in_vec;
               len_next   = eff_len;
               rev_next   = in_rev;
               cnt_next   = '0;
               if (bypass_en) begin
                  data_next  = bypass_data;
                  index_next = len_max;
                  last_next  = 1'b1;
               end else begin
                  data_next  = pick_lane;
                  index_next = pick_idx;
                  last_next  = (eff_len == one);
               end
            end
         end
         STREAM: begin
            if (out_ready) begin
               if (last_reg) begin
                  state_next = IDLE;
                  last_next  = 1'b0;
               end else begin
                  cnt_next   = beat_next;
                  data_next  = pick_lane;
                  index_next = pick_idx;
                  last_next  = (beat_next == (len_reg - one));
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         vec_reg   <= '0;
         len_reg   <= '0;
         rev_reg   <= 1'b0;
         cnt_reg   <= '0;
         data_reg  <= '0;
         index_reg <= '0;
         last_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         vec_reg   <= vec_next;
         len_reg   <= len_next;
         rev_reg   <= rev_next;
         cnt_reg   <= cnt_next;
         data_reg  <= data_next;
         index_reg <= index_next;
         last_reg  <= last_next;
      end
   end

   logic unused_advance;
   assign unused_advance = advance;

endmodule

// File: tb/tb_lane_serializer.sv
// Self-checking bench for lane_serializer: queue-based beat model checked every
// cycle, plus literal expectations per directed scenario.
module tb_lane_serializer;

   localparam int AS = 9;
   localparam int DS = 16;
   localparam int LS = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [AS*DS-1:0] in_vec = '0;
   logic [LS-1:0]    in_len = '0;
   logic             in_rev = 1'b0;
   logic             bypass_en = 1'b0;
   logic [DS-1:0]    bypass_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [DS-1:0]    out_data;
   logic [LS-1:0]    out_index;
   logic             out_last;

   lane_serializer #(
      .array_size   (AS),
      .data_size    (DS),
      .dimdata_size (LS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_vec      (in_vec),
      .in_len      (in_len),
      .in_rev      (in_rev),
      .bypass_en   (bypass_en),
      .bypass_data (bypass_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_index   (out_index),
      .out_last    (out_last)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DS-1:0] d;
      logic [LS-1:0] i;
      logic          l;
   } beat_t;

   beat_t exp_q[$];
   beat_t got_q[$];
   int    total = 0;
   int    bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   function automatic logic [AS*DS-1:0] ramp(input logic [DS-1:0] base);
      logic [AS*DS-1:0] r;
      r = '0;
      for (int k = 0; k < AS; k++) r[k*DS +: DS] = base + DS'(k);
      return r;
   endfunction

   // Expected beats of an accepted load, from the lane-order rules.
   function automatic void push_load();
      int    eff;
      int    lane;
      beat_t b;
      eff = ((in_len == 0) || (int'(in_len) > AS)) ? AS : int'(in_len);
      if (bypass_en) begin
         b.d = bypass_data;
         b.i = LS'(AS);
         b.l = 1'b1;
         exp_q.push_back(b);
      end else begin
         for (int j = 0; j < eff; j++) begin
            lane = in_rev ? (eff - 1 - j) : j;
            b.d = in_vec[lane*DS +: DS];
            b.i = LS'(lane);
            b.l = (j == eff - 1);
            exp_q.push_back(b);
         end
      end
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
      end else begin
         check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
         check("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
         if (out_valid && (exp_q.size() > 0)) begin
            check("out_data", 32'(out_data), 32'(exp_q[0].d));
            check("out_index", 32'(out_index), 32'(exp_q[0].i));
            check("out_last", 32'(out_last), 32'(exp_q[0].l));
            if (out_ready) begin
               got_q.push_back({out_data, out_index, out_last});
               void'(exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) push_load();
      end
   end

   task automatic load(input logic [AS*DS-1:0] v, input int len, input logic rev,
                       input logic byp, input logic [DS-1:0] bd);
      in_vec      = v;
      in_len      = LS'(len);
      in_rev      = rev;
      bypass_en   = byp;
      bypass_data = bd;
      in_valid    = 1'b1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      check("load_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) return;
      end
      check("idle_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic found;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_index", 32'(out_index), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);

      // Ascending full stream; in_vec is scrambled after acceptance.
      got_q.delete();
      load(ramp(16'h0000), 9, 1'b0, 1'b0, 16'h0);
      check("asc_first_valid", 32'(out_valid), 32'd1);
      in_vec = {(AS*DS){1'b1}};
      wait_idle();
      check("asc_count", 32'(got_q.size()), 32'd9);
      for (int j = 0; j < got_q.size(); j++) begin
         check("asc_data", 32'(got_q[j].d), 32'(j));
         check("asc_index", 32'(got_q[j].i), 32'(j));
         check("asc_last", 32'(got_q[j].l), 32'(j == 8));
      end

      // Descending partial stream.
      got_q.delete();
      load(ramp(16'h0A00), 4, 1'b1, 1'b0, 16'h0);
      wait_idle();
      check("desc_count", 32'(got_q.size()), 32'd4);
      if (got_q.size() == 4) begin
         check("desc_d0", 32'(got_q[0].d), 32'h0A03);
         check("desc_d1", 32'(got_q[1].d), 32'h0A02);
         check("desc_d2", 32'(got_q[2].d), 32'h0A01);
         check("desc_d3", 32'(got_q[3].d), 32'h0A00);
         check("desc_last2", 32'(got_q[2].l), 32'd0);
         check("desc_last3", 32'(got_q[3].l), 32'd1);
      end
      check("desc_idle_ready", 32'(in_ready), 32'd1);
      check("desc_idle_valid", 32'(out_valid), 32'd0);

      // Back-pressure on beat 2 for three cycles.
      got_q.delete();
      load(ramp(16'h0100), 9, 1'b0, 1'b0, 16'h0);
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         if (out_valid && (out_index == 2)) found = 1'b1;
         else begin
            @(posedge clk);
            #1;
         end
      end
      check("bp_found_beat2", 32'(found), 32'd1);
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("bp_hold_data", 32'(out_data), 32'h0102);
         check("bp_hold_index", 32'(out_index), 32'd2);
         check("bp_hold_last", 32'(out_last), 32'd0);
      end
      out_ready = 1'b1;
      wait_idle();
      check("bp_count", 32'(got_q.size()), 32'd9);
      for (int j = 0; j < got_q.size(); j++)
         check("bp_data", 32'(got_q[j].d), 32'h0100 + 32'(j));

      // Bypass beat.
      got_q.delete();
      load(ramp(16'h0700), 5, 1'b0, 1'b1, 16'hBEEF);
      wait_idle();
      check("byp_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() == 1) begin
         check("byp_data", 32'(got_q[0].d), 32'hBEEF);
         check("byp_index", 32'(got_q[0].i), 32'd9);
         check("byp_last", 32'(got_q[0].l), 32'd1);
      end

      // Clamp: len 0 then len 20, second load offered while the first streams.
      got_q.delete();
      load(ramp(16'h0200), 0, 1'b0, 1'b0, 16'h0);
      load(ramp(16'h0300), 20, 1'b0, 1'b0, 16'h0);
      wait_idle();
      check("clamp_count", 32'(got_q.size()), 32'd18);
      if (got_q.size() == 18) begin
         check("clamp0_first", 32'(got_q[0].d), 32'h0200);
         check("clamp0_last_d", 32'(got_q[8].d), 32'h0208);
         check("clamp0_last_l", 32'(got_q[8].l), 32'd1);
         check("clamp20_first", 32'(got_q[9].d), 32'h0300);
         check("clamp20_last_d", 32'(got_q[17].d), 32'h0308);
         check("clamp20_last_i", 32'(got_q[17].i), 32'd8);
      end

      // Reset in the middle of a stream, then a fresh load.
      got_q.delete();
      load(ramp(16'h0400), 9, 1'b0, 1'b0, 16'h0);
      for (int k = 0; k < 20 && got_q.size() < 3; k++) begin
         @(posedge clk);
         #1;
      end
      check("rst_mid_beats", 32'(got_q.size()), 32'd3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_ready", 32'(in_ready), 32'd1);
      check("rst_mid_last", 32'(out_last), 32'd0);
      check("rst_mid_data", 32'(out_data), 32'd0);
      got_q.delete();
      load(ramp(16'h0500), 9, 1'b0, 1'b0, 16'h0);
      wait_idle();
      check("post_rst_count", 32'(got_q.size()), 32'd9);
      if (got_q.size() == 9) begin
         check("post_rst_d0", 32'(got_q[0].d), 32'h0500);
         check("post_rst_i0", 32'(got_q[0].i), 32'd0);
         check("post_rst_d8", 32'(got_q[8].d), 32'h0508);
      end

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_serializer.md
LANE_SERIALIZER -- requirements
Module: lane_serializer

Interface
REQ-001 Parameter array_size, default 9, number of data lanes in the input vector.
REQ-002 Parameter data_size, default 16, width in bits of one lane word.
REQ-003 Parameter dimdata_size, default 16, width in bits of the length and index fields.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  a vector load is offered.
REQ-007 in_ready  output  1  the block accepts a load this cycle.
REQ-008 in_vec  input  array_size*data_size  lane k occupies bits [k*data_size +: data_size].
REQ-009 in_len  input  dimdata_size  number of lanes to emit.
REQ-010 in_rev  input  1  0 = ascending lane order, 1 = descending lane order.
REQ-011 bypass_en  input  1  emit bypass_data as a single beat instead of lanes.
REQ-012 bypass_data  input  data_size  bypass word.
REQ-013 out_valid  output  1  out_data is valid.
REQ-014 out_ready  input  1  the consumer accepts the current beat.
REQ-015 out_data  output  data_size  emitted word (registered).
REQ-016 out_index  output  dimdata_size  source lane number of out_data; array_size for a bypass beat.
REQ-017 out_last  output  1  final beat of the current load.

Function
REQ-018 The FSM SHALL have two states, IDLE and STREAM.
REQ-019 in_ready SHALL be 1 only in IDLE.
REQ-020 A load SHALL be accepted when in_valid && in_ready; on acceptance the block SHALL capture in_vec, the effective length, in_rev, bypass_en and bypass_data, and enter STREAM.
REQ-021 Effective length: if in_len is 0 or greater than array_size, it SHALL be array_size; otherwise it SHALL be in_len.
REQ-022 If a load is accepted in cycle N, out_valid SHALL be 1 from cycle N+1, with the first beat on out_data.
REQ-023 In ascending mode, beat j SHALL carry lane j for j = 0..len-1.
REQ-024 In descending mode, beat j SHALL carry lane len-1-j for j = 0..len-1.
REQ-025 Lane selection SHALL always come from the captured vector; changes on in_vec after acceptance SHALL have no effect.
REQ-026 If bypass_en was captured, the block SHALL emit exactly one beat: out_data = bypass_data, out_index = array_size, out_last = 1.
REQ-027 A beat SHALL advance only when out_valid && out_ready.
REQ-028 While out_valid is 1 and out_ready is 0, out_data, out_index and out_last SHALL hold unchanged.
REQ-029 out_last SHALL be 1 only on the final beat of a load.
REQ-030 When the last beat is accepted, the FSM SHALL return to IDLE and out_valid SHALL be 0 in the following cycle.
- The next load therefore has a one-cycle gap after the last beat.
REQ-031 The lane counter SHALL never index a lane at or beyond array_size.
REQ-032 out_index SHALL be zero-extended to dimdata_size.

Reset
REQ-033 When reset is 1 at a clock edge, the FSM SHALL enter IDLE regardless of state.
- A stream in progress SHALL be discarded without further beats.
REQ-034 Output values after reset SHALL be: out_valid = 0, out_last = 0, out_data = 0, out_index = 0, in_ready = 1 from the first cycle after reset deasserts.
REQ-035 The captured vector SHALL be cleared to 0 on reset.

Structure
REQ-036 A shared package SHALL hold:
- the FSM state encoding (IDLE, STREAM);
- the default array_size, data_size and dimdata_size values;
- the bypass index value (= array_size).
REQ-037 The lane extraction (vector >> data_size*index) SHALL be one combinational sub-module, lane_pick; all registers SHALL live in lane_serializer.

Verification
REQ-038 Ascending stream, array_size = 9: load lanes 0x0000..0x0008, in_len = 9, in_rev = 0, out_ready = 1.
- Required: 9 consecutive beats, data 0x0000..0x0008, index 0..8, out_last on beat 8 only, first beat in cycle N+1.
REQ-039 Descending partial stream: in_len = 4, in_rev = 1.
- Required: data lanes 3, 2, 1, 0; out_last on the 4th beat; IDLE and in_ready = 1 one cycle later.
REQ-040 Back-pressure: out_ready = 0 for 3 cycles at beat 2.
- Required: beat 2 data, index and last held stable for 3 cycles; no beat lost or duplicated.
REQ-041 Bypass: bypass_en = 1, bypass_data = 0xBEEF.
- Required: a single beat 0xBEEF, out_index = 9, out_last = 1.
REQ-042 Clamp: in_len = 0 and, separately, in_len = 20.
- Required: 9 beats in each case.
- in_valid held high while in STREAM is not accepted until IDLE.
REQ-043 Reset after beat 3 of 9.
- Required: out_valid = 0 next cycle, in_ready = 1.
- A new load then streams correctly from lane 0.
